// File: rtl/mem_arb.sv
// mem_arb: single-port memory arbiter between instruction fetch (F) and load/store data (D).
// Build option MEM_ARB_RR_FAIR_EN alternates F/D under contention; default gives D fixed priority.
module mem_arb #(
  parameter int MEM_LAT = 1,
  parameter int AW      = 16,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_ack,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;
  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            gnt_d_q, gnt_d_d;
  logic            f_ack_q, f_ack_d;
  logic            d_ack_q, d_ack_d;
  logic [DW-1:0]   f_rdata_q, f_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            m_en_q, m_en_d;
  logic            m_we_q, m_we_d;
  logic [AW-1:0]   m_addr_q, m_addr_d;
  logic [DW-1:0]   m_wdata_q, m_wdata_d;
  logic            pick_d;

`ifdef MEM_ARB_RR_FAIR_EN
  logic last_d_q, last_d_d;

  // Under contention, serve whichever port did not win the previous grant.
  assign pick_d = d_req && (!f_req || !last_d_q);

  always_comb begin
    last_d_d = last_d_q;
    if (state_q == IDLE && (f_req || d_req)) last_d_d = pick_d;
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) last_d_q <= 1'b0;
    else        last_d_q <= last_d_d;
  end
`else
  assign pick_d = d_req;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt_d_d   = gnt_d_q;
    f_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    f_rdata_d = f_rdata_q;
    d_rdata_d = d_rdata_q;
    m_en_d    = m_en_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    case (state_q)
      IDLE: begin
        if (f_req || d_req) begin
          gnt_d_d   = pick_d;
          m_en_d    = 1'b1;
          m_we_d    = pick_d && d_we;
          m_addr_d  = pick_d ? d_addr : f_addr;
          m_wdata_d = pick_d ? d_wdata : '0;
          cnt_d     = CNT_INIT;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (gnt_d_q) begin
            d_ack_d = 1'b1;
            if (!m_we_q) d_rdata_d = m_rdata;
          end else begin
            f_ack_d   = 1'b1;
            f_rdata_d = m_rdata;
          end
          m_en_d  = 1'b0;
          m_we_d  = 1'b0;
          state_d = DONE;
        end
      end
      // One turnaround cycle while the ack is visible; requests are ignored here.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      gnt_d_q   <= 1'b0;
      f_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
      m_en_q    <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_d_q   <= gnt_d_d;
      f_ack_q   <= f_ack_d;
      d_ack_q   <= d_ack_d;
      f_rdata_q <= f_rdata_d;
      d_rdata_q <= d_rdata_d;
      m_en_q    <= m_en_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
    end
  end

  assign f_ack   = f_ack_q;
  assign d_ack   = d_ack_q;
  assign f_rdata = f_rdata_q;
  assign d_rdata = d_rdata_q;
  assign m_en    = m_en_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign busy    = (state_q != IDLE);

endmodule
